// File: rtl/tm_lif_pkg.sv
// tm_lif_pkg: shared FSM state type and datapath widths for the TM_LIF scheduler
package tm_lif_pkg;
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SWEEP, ST_DRAIN} state_t;
    localparam int VMEM_W = 10;
    localparam int SYN_W = 10;
    localparam int LIF_LAT = 3;
endpackage

// File: rtl/tm_lif_vmem_ram.sv
// tm_lif_vmem_ram: membrane state store, one write port and one registered read port
module tm_lif_vmem_ram
    import tm_lif_pkg::*;
#(
    parameter int N_NEURONS = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_in,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [VMEM_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [VMEM_W-1:0] rdata
);
    logic [VMEM_W-1:0] mem [N_NEURONS];
    always_ff @(posedge clk_in) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/tm_lif_scheduler.sv
// tm_lif_scheduler: sweeps every neuron through the LIF pipeline per timestep,
// writes membranes back and emits spiking addresses as handshaked events
module tm_lif_scheduler
    import tm_lif_pkg::*;
#(
    parameter int N_NEURONS = 256,
    parameter int ADDR_W = 8,
    parameter int SPK_FIFO_DEPTH = 8
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [15:0]       ts_cnt,
    output logic [ADDR_W-1:0] syn_addr,
    input  logic [SYN_W-1:0]  syn_data,
    output logic [VMEM_W-1:0] lif_vmem,
    output logic [SYN_W-1:0]  lif_syn,
    input  logic [VMEM_W-1:0] lif_vmem_ret,
    input  logic              lif_spike,
    output logic              spk_valid,
    input  logic              spk_ready,
    output logic [ADDR_W-1:0] spk_addr
);
    localparam int SD = LIF_LAT + 1;
    localparam int FW = $clog2(SPK_FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_NEURONS - 1);

    state_t state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [SD-1:0] vld;
    logic [ADDR_W-1:0] addr_sr [SD];
    logic issue, credit, push, pop, ram_we;
    logic [VMEM_W-1:0] ram_q, ram_wd;
    logic [ADDR_W-1:0] ram_wa;
    logic [ADDR_W-1:0] fifo [SPK_FIFO_DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [FW:0] fifo_cnt;

    always_ff @(posedge clk_in) begin
        if (!reset_n) state <= ST_INIT;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  state_nxt = ptr == LAST ? ST_IDLE : ST_INIT;
            ST_IDLE:  state_nxt = start ? ST_SWEEP : ST_IDLE;
            ST_SWEEP: state_nxt = issue && ptr == LAST ? ST_DRAIN : ST_SWEEP;
            ST_DRAIN: state_nxt = done ? ST_IDLE : ST_DRAIN;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // Credit counts every in-flight neuron as a future push so the FIFO can never overflow
    always_comb begin
        credit = int'(fifo_cnt) + $countones(vld) < SPK_FIFO_DEPTH;
        issue = state == ST_SWEEP && credit;
        busy = state != ST_IDLE;
        done = state == ST_DRAIN && vld == '0;
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            ptr <= '0;
            vld <= '0;
            ts_cnt <= '0;
        end else begin
            ptr <= state == ST_INIT ? (ptr == LAST ? '0 : ptr + 1'b1) :
                   state == ST_IDLE ? '0 : ptr + ADDR_W'(issue);
            vld <= {vld[SD-2:0], issue};
            ts_cnt <= ts_cnt + 16'(done);
        end
        addr_sr[0] <= ptr;
        for (int i = 1; i < SD; i++) addr_sr[i] <= addr_sr[i-1];
    end

    assign ram_we = reset_n && (state == ST_INIT || vld[SD-1]);
    assign ram_wa = state == ST_INIT ? ptr : addr_sr[SD-1];
    assign ram_wd = state == ST_INIT ? '0 : lif_vmem_ret;

    tm_lif_vmem_ram #(.N_NEURONS(N_NEURONS), .ADDR_W(ADDR_W)) u_ram (
        .clk_in(clk_in),
        .we(ram_we),
        .waddr(ram_wa),
        .wdata(ram_wd),
        .re(issue),
        .raddr(ptr),
        .rdata(ram_q)
    );

    assign syn_addr = ptr;
    assign lif_vmem = vld[0] ? ram_q : '0;
    assign lif_syn = vld[0] ? syn_data : '0;

    assign push = vld[SD-1] && lif_spike;
    assign pop = spk_valid && spk_ready;

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr + FW'(push);
            rd_ptr <= rd_ptr + FW'(pop);
            fifo_cnt <= fifo_cnt + (FW+1)'(push) - (FW+1)'(pop);
        end
        if (push) fifo[wr_ptr] <= addr_sr[SD-1];
    end

    assign spk_valid = fifo_cnt != '0;
    assign spk_addr = spk_valid ? fifo[rd_ptr] : '0;
endmodule

// File: tb/tb_tm_lif_scheduler.sv
// tb_tm_lif_scheduler: scoreboard bench with synapse RAM and 3-stage LIF models
module tb_tm_lif_scheduler;
    localparam int N = 16;
    localparam int AW = 4;
    localparam int DEPTH = 8;

    typedef struct {int addr; int at;} ev_t;

    logic clk_in = 0;
    logic reset_n = 0;
    logic start = 0;
    logic busy, done, spk_valid;
    logic [15:0] ts_cnt;
    logic [AW-1:0] syn_addr, spk_addr;
    logic [9:0] syn_data = '0;
    logic [9:0] lif_vmem, lif_syn, lif_vmem_ret;
    logic lif_spike;
    logic spk_ready = 1;

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;
    int start_cyc = 0;
    int exp_ts = 0;
    logic spike_all = 0;
    logic [9:0] syn_mem [N];
    logic [9:0] ref_v [N];
    logic [10:0] p1 = '0, p2 = '0, p3 = '0;
    logic [9:0] vq [$];
    logic [9:0] sq [$];
    ev_t evq [$];

    tm_lif_scheduler #(.N_NEURONS(N), .ADDR_W(AW), .SPK_FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in),
        .reset_n(reset_n),
        .start(start),
        .busy(busy),
        .done(done),
        .ts_cnt(ts_cnt),
        .syn_addr(syn_addr),
        .syn_data(syn_data),
        .lif_vmem(lif_vmem),
        .lif_syn(lif_syn),
        .lif_vmem_ret(lif_vmem_ret),
        .lif_spike(lif_spike),
        .spk_valid(spk_valid),
        .spk_ready(spk_ready),
        .spk_addr(spk_addr)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc_n <= cyc_n + 1;
    always @(posedge clk_in) syn_data <= syn_mem[syn_addr];

    // LIF model: vmem_o = vmem_i + syn_i[8:0]; spikes on syn_i[9] or when spike_all is set
    always @(posedge clk_in) begin
        p1 <= {spike_all | lif_syn[9], lif_vmem + {1'b0, lif_syn[8:0]}};
        p2 <= p1;
        p3 <= p2;
    end
    assign lif_vmem_ret = p3[9:0];
    assign lif_spike = p3[10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (spk_valid && spk_ready) begin
            if (evq.size() == 0) check("spk_unexpected", spk_valid, 0);
            else begin
                check("spk_addr", spk_addr, evq[0].addr);
                if (evq[0].at >= 0) check("spk_cycle", cyc_n, evq[0].at);
                void'(evq.pop_front());
            end
        end
    end

    task automatic pulse_start(input bit timed);
        @(posedge clk_in); #1;
        start = 1;
        start_cyc = cyc_n;
        for (int k = 0; k < N; k++) begin
            if (timed) begin
                vq.push_back(ref_v[k]);
                sq.push_back(syn_mem[k]);
            end
            if (spike_all || syn_mem[k][9]) evq.push_back('{addr: k, at: timed ? start_cyc + 6 + k : -1});
            ref_v[k] = ref_v[k] + {1'b0, syn_mem[k][8:0]};
        end
        @(posedge clk_in); #1;
        start = 0;
    endtask

    task automatic wait_done(input bit timed, input int poke);
        int c, got, extra;
        got = -1;
        extra = 0;
        for (int i = 0; i < 8 * N + 100 && got < 0; i++) begin
            @(negedge clk_in);
            c = cyc_n - start_cyc;
            if (timed && c >= 2 && c <= N + 1) begin
                check("lif_vmem", lif_vmem, vq.pop_front());
                check("lif_syn", lif_syn, sq.pop_front());
            end
            if (c == poke) start = 1;
            else if (c == poke + 1) start = 0;
            if (done) begin
                got = c;
                check("busy_at_done", busy, 1);
            end
        end
        start = 0;
        check("done_seen", got >= 0, 1);
        if (timed) check("done_latency", got, N + 5);
        exp_ts++;
        @(negedge clk_in);
        check("busy_after_done", busy, 0);
        check("ts_cnt", ts_cnt, exp_ts);
        repeat (N) begin
            @(negedge clk_in);
            extra += int'(done);
        end
        check("extra_done", extra, 0);
    endtask

    task automatic count_init();
        int n;
        @(negedge clk_in);
        reset_n = 1;
        n = int'(busy);
        repeat (N + 4) begin
            @(negedge clk_in);
            n += int'(busy);
        end
        check("init_busy_cycles", n, N);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            syn_mem[k] = 10'd5;
            ref_v[k] = '0;
        end
        repeat (3) @(negedge clk_in);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_ts_cnt", ts_cnt, 0);
        check("rst_spk_valid", spk_valid, 0);
        check("rst_spk_addr", spk_addr, 0);
        check("rst_syn_addr", syn_addr, 0);
        check("rst_lif_vmem", lif_vmem, 0);
        check("rst_lif_syn", lif_syn, 0);
        count_init();
        repeat (3) begin
            pulse_start(1);
            wait_done(1, -1);
        end
        check("ts_after_3", ts_cnt, 3);
        syn_mem[2] = 10'h205;
        syn_mem[5] = 10'h205;
        pulse_start(1);
        wait_done(1, 4);
        syn_mem[2] = 10'd5;
        syn_mem[5] = 10'd5;
        spike_all = 1;
        @(posedge clk_in); #1;
        spk_ready = 0;
        pulse_start(0);
        repeat (30) @(negedge clk_in);
        check("bp_issue_ptr", syn_addr, DEPTH);
        check("bp_spk_valid", spk_valid, 1);
        check("bp_spk_addr", spk_addr, 0);
        check("bp_busy", busy, 1);
        check("bp_no_done", done, 0);
        @(negedge clk_in);
        check("bp_spk_addr_hold", spk_addr, 0);
        @(posedge clk_in); #1;
        spk_ready = 1;
        wait_done(0, -1);
        check("bp_events_left", evq.size(), 0);
        spike_all = 0;
        pulse_start(1);
        wait_done(1, -1);
        spike_all = 1;
        @(posedge clk_in); #1;
        start = 1;
        @(posedge clk_in); #1;
        start = 0;
        for (int i = 0; i < 20 && syn_addr != 3; i++) @(negedge clk_in);
        check("rst_mid_addr", syn_addr, 3);
        reset_n = 0;
        for (int k = 0; k < N; k++) ref_v[k] = '0;
        exp_ts = 0;
        count_init();
        check("rst_mid_ts_cnt", ts_cnt, 0);
        check("rst_mid_spk_valid", spk_valid, 0);
        spike_all = 0;
        for (int k = 0; k < N; k++) syn_mem[k] = 10'(k);
        pulse_start(1);
        wait_done(1, -1);
        check("events_left", evq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/tm_lif_scheduler.md
# tm_lif_scheduler

Time-multiplexing sequencer and state store on the far side of the TM_LIF neuron pipeline. On each timestep tick it sweeps all neuron addresses: it reads membrane state from its own vmem RAM and synaptic input from an external synapse RAM, and feeds both to the LIF pipeline. Three cycles later it captures the updated membrane and spike flag, writes the membrane back, and emits spiking neuron addresses as address-events over a valid/ready handshake.

## Interface
- `N_NEURONS`, 256: neurons per sweep; must be ≥ 4 and ≤ 2^ADDR_W.
- `ADDR_W`, 8: neuron address width.
- `SPK_FIFO_DEPTH`, 8: address-event FIFO depth; power of two, ≥ 8.
- `clk_in`  in  1: single clock, all logic on posedge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: timestep tick; one-cycle pulse; ignored unless the FSM is in IDLE.
- `busy`  out  1: high in INIT, SWEEP and DRAIN.
- `done`  out  1: one-cycle pulse after the last write-back of a sweep.
- `ts_cnt`  out  16: completed-timestep counter; increments on `done`; wraps at 0xFFFF→0.
- `syn_addr`  out  ADDR_W: synapse RAM read address; data returns one cycle later.
- `syn_data`  in  10: synapse RAM read data.
- `lif_vmem`  out  10: drives the LIF `vmem_i`; bit 9 is the refractory/sign flag, bits 8:0 the magnitude.
- `lif_syn`  out  10: drives the LIF `syn_i`.
- `lif_vmem_ret`  in  10: LIF `vmem_o`, valid 3 cycles after the matching `lif_vmem`.
- `lif_spike`  in  1: LIF `LIF_spike`, aligned with `lif_vmem_ret`.
- `spk_valid`  out  1: address-event valid.
- `spk_ready`  in  1: address-event ready.
- `spk_addr`  out  ADDR_W: address of the spiking neuron.

## Operation
- **FSM states:** INIT, IDLE, SWEEP, DRAIN.
  - Reset enters INIT.
  - INIT writes 0 to every vmem RAM word, one address per cycle (N_NEURONS cycles), then goes to IDLE.
  - `start` in IDLE moves to SWEEP with issue pointer = 0.
  - SWEEP issues one neuron per cycle when credit allows. After issuing address N_NEURONS−1 it moves to DRAIN.
  - DRAIN waits until the in-flight valid shift register is empty, pulses `done`, and returns to IDLE.
- **Issue of address k at cycle t:**
  - vmem RAM read and `syn_addr` = k at cycle t.
  - At t+1, `lif_vmem` = RAM data and `lif_syn` = `syn_data`; this is LIF stage @0.
  - Valid and address k enter a 4-deep shift register (vld/addr), so they emerge at t+4, aligned with LIF @3.
- **Write-back at t+4:** vmem RAM[k] ← `lif_vmem_ret`. If `lif_spike` = 1, push k into the spike FIFO.
- **Credit:** issue only when fifo_count + in-flight count (0..4) < SPK_FIFO_DEPTH, so a push never finds the FIFO full.
  - When credit is denied, the issue pointer holds. `lif_vmem`/`lif_syn` are don't-care, with valid = 0 in the shift register.
  - The LIF pipeline has no enable; bubbles are tracked only by the valid bits.
- **RAM:** single write port, single registered read port.
  - Read and write never collide on the same address, because a neuron is re-read only in the next sweep and N_NEURONS ≥ 4.
  - A same-cycle read of address j and write of address k with j≠k is legal.
- **Spike FIFO:** pop on `spk_valid && spk_ready`. Push and pop in the same cycle are allowed, including when full−1 or empty.
- **Reset mid-sweep:**
  - Shift register valids clear, so any LIF outputs still emerging are ignored (no write, no push).
  - FIFO empties and `ts_cnt` clears.
  - INIT re-zeroes the RAM.

## Timing
- Reset values:
  - `busy` = 1 (INIT)
  - `done` = 0
  - `ts_cnt` = 0
  - `spk_valid` = 0
  - `spk_addr` = 0
  - `syn_addr` = 0
  - `lif_vmem` = 0
  - `lif_syn` = 0
- Issue-to-write-back latency is 4 cycles; issue-to-`spk_valid` is 5 cycles (FIFO is registered, first-word registered output).
- An unstalled sweep takes `start` → `done` = N_NEURONS + 5 cycles.
- `done` and the `ts_cnt` increment occur in the same cycle; `busy` falls the cycle after `done`.
- `spk_addr` is stable while `spk_valid && !spk_ready`.

## Structure
- Shared package `tm_lif_pkg` holds:
  - the FSM state enum
  - VMEM_W = 10, SYN_W = 10, LIF_LAT = 3
- Sub-module `tm_lif_vmem_ram` is the N_NEURONS × 10 RAM with registered read, inferable as block RAM.
- The spike FIFO stays inline.

## Test plan
- **Reset/INIT:** release `reset_n`, N=8 → `busy` high 8 cycles, then IDLE; first sweep with model LIF returning `vmem_i`+`syn_i` reads all vmem = 0.
- **Accumulation:** `syn_data` = 5 for all, model LIF echoes sum; 3 sweeps → RAM holds 15 everywhere; `ts_cnt` = 3; each `done` exactly N+5 cycles after `start`.
- **Spikes:** model LIF spikes on addresses 2 and 5, `spk_ready` = 1 → events 2 then 5, each 5 cycles after its issue, no duplicates.
- **Back-pressure:** every neuron spikes, `spk_ready` = 0 → issue stops with fifo_count + inflight = 8. Then raising `spk_ready` → all N addresses emitted in order, none lost, RAM fully written.
- **Ignored start:** `start` pulsed mid-sweep → no effect, single `done`.
- **Mid-sweep reset:** assert `reset_n` = 0 at issue address 3 for 1 cycle → no writes or events from stale LIF outputs; INIT re-runs; `ts_cnt` = 0.
